// File: rtl/sr_latch_sync.sv
// Clocked bank of active-low set/reset latches with input synchronizers.
// The forbidden 0,0 request drives q=qn=1 and leaves the stored bit untouched.
module sr_latch_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter bit Q_RESET     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_n,
    input  logic [WIDTH-1:0] r_n,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] invalid,
    output logic             invalid_seen
);

    logic [WIDTH-1:0] s_sync;
    logic [WIDTH-1:0] r_sync;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_sync = s_n;
            assign r_sync = r_n;
        end else begin : g_sync
            // Flops reset to the inactive level so reset never looks like a request.
            logic [WIDTH-1:0] s_pipe_q [SYNC_STAGES];
            logic [WIDTH-1:0] r_pipe_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        s_pipe_q[i] <= '1;
                        r_pipe_q[i] <= '1;
                    end
                end else begin
                    s_pipe_q[0] <= s_n;
                    r_pipe_q[0] <= r_n;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        s_pipe_q[i] <= s_pipe_q[i-1];
                        r_pipe_q[i] <= r_pipe_q[i-1];
                    end
                end
            end

            assign s_sync = s_pipe_q[SYNC_STAGES-1];
            assign r_sync = r_pipe_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qn_q, qn_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic             seen_q, seen_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qn_d    = qn_q;
        inv_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({s_sync[i], r_sync[i]})
                2'b01: state_d[i] = 1'b1;
                2'b10: state_d[i] = 1'b0;
                2'b00: inv_d[i]   = 1'b1;
                default: ;
            endcase
            // Hold and release from forbidden both present the stored bit.
            q_d[i]  = inv_d[i] ? 1'b1 : state_d[i];
            qn_d[i] = inv_d[i] ? 1'b1 : ~state_d[i];
        end
        seen_d = (|inv_d) | (seen_q & ~clr_sticky);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= {WIDTH{Q_RESET}};
            q_q     <= {WIDTH{Q_RESET}};
            qn_q    <= {WIDTH{~Q_RESET}};
            inv_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qn_q    <= qn_d;
            inv_q   <= inv_d;
            seen_q  <= seen_d;
        end
    end

    assign q            = q_q;
    assign qn           = qn_q;
    assign invalid      = inv_q;
    assign invalid_seen = seen_q;

endmodule

// File: tb/tb_sr_latch_sync.sv
// Directed bench for sr_latch_sync: behavioural reference with per-cycle compare
// plus literal checkpoints for each scenario.
module tb_sr_latch_sync;

    localparam int W    = 4;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] s_n;
    logic [W-1:0] r_n;
    logic         clr_sticky;
    logic [W-1:0] q, qn, invalid;
    logic         invalid_seen;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    sr_latch_sync #(.WIDTH(W), .SYNC_STAGES(SYNC), .Q_RESET(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_n          (s_n),
        .r_n          (r_n),
        .clr_sticky   (clr_sticky),
        .q            (q),
        .qn           (qn),
        .invalid      (invalid),
        .invalid_seen (invalid_seen)
    );

    always #5 clk = ~clk;

    // Reference: inputs seen SYNC edges late, then plain latch truth table.
    logic [W-1:0] dl_s [SYNC];
    logic [W-1:0] dl_r [SYNC];
    logic [W-1:0] m_store, m_q, m_qn, m_inv;
    logic         m_seen;

    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] es, er, st, nq, nqn, ninv;
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) begin
                dl_s[i] <= '1;
                dl_r[i] <= '1;
            end
            m_store <= '0;
            m_q     <= '0;
            m_qn    <= '1;
            m_inv   <= '0;
            m_seen  <= 1'b0;
        end else begin
            es = dl_s[0];
            er = dl_r[0];
            st = m_store;
            for (int l = 0; l < W; l++) begin
                if (!es[l] && !er[l]) begin
                    nq[l] = 1'b1; nqn[l] = 1'b1; ninv[l] = 1'b1;
                end else begin
                    if (!es[l]) st[l] = 1'b1;
                    else if (!er[l]) st[l] = 1'b0;
                    nq[l] = st[l]; nqn[l] = !st[l]; ninv[l] = 1'b0;
                end
            end
            for (int i = 0; i < SYNC - 1; i++) begin
                dl_s[i] <= dl_s[i+1];
                dl_r[i] <= dl_r[i+1];
            end
            dl_s[SYNC-1] <= s_n;
            dl_r[SYNC-1] <= r_n;
            m_store <= st;
            m_q     <= nq;
            m_qn    <= nqn;
            m_inv   <= ninv;
            m_seen  <= (ninv != '0) ? 1'b1 : (clr_sticky ? 1'b0 : m_seen);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (q === m_q && qn === m_qn && invalid === m_inv && invalid_seen === m_seen)
                passed++;
            else
                $display("FAIL model_cmp t=%0t: dut q=%b qn=%b inv=%b seen=%b, model q=%b qn=%b inv=%b seen=%b",
                         $time, q, qn, invalid, invalid_seen, m_q, m_qn, m_inv, m_seen);
        end
    end

    task automatic expect_out(input string nm, input logic [W-1:0] eq, input logic [W-1:0] eqn,
                              input logic [W-1:0] einv, input logic eseen);
        checks++;
        if (q === eq && qn === eqn && invalid === einv && invalid_seen === eseen)
            passed++;
        else
            $display("FAIL %s: got q=%b qn=%b inv=%b seen=%b, want q=%b qn=%b inv=%b seen=%b",
                     nm, q, qn, invalid, invalid_seen, eq, eqn, einv, eseen);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; s_n = '1; r_n = '1; clr_sticky = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        expect_out("reset_immediate", 4'b0000, 4'b1111, 4'b0000, 1'b0);
        #19 rst_n = 1'b1;
        tick(10);
        expect_out("reset_hold_10", 4'b0000, 4'b1111, 4'b0000, 1'b0);

        // Set on lane 0, three-cycle latency.
        s_n[0] = 1'b0;
        tick(2);
        expect_out("set_not_yet", 4'b0000, 4'b1111, 4'b0000, 1'b0);
        tick(1);
        expect_out("set_at_3", 4'b0001, 4'b1110, 4'b0000, 1'b0);
        tick(7);
        s_n[0] = 1'b1;
        tick(5);
        expect_out("set_held", 4'b0001, 4'b1110, 4'b0000, 1'b0);

        // Reset on lane 0.
        r_n[0] = 1'b0;
        tick(2);
        expect_out("rst_not_yet", 4'b0001, 4'b1110, 4'b0000, 1'b0);
        tick(1);
        expect_out("rst_at_3", 4'b0000, 4'b1111, 4'b0000, 1'b0);
        tick(7);
        r_n[0] = 1'b1;
        tick(5);
        expect_out("rst_held", 4'b0000, 4'b1111, 4'b0000, 1'b0);

        // Forbidden from stored 0, simultaneous release.
        s_n[0] = 1'b0; r_n[0] = 1'b0;
        tick(3);
        expect_out("forbid_from0", 4'b0001, 4'b1111, 4'b0001, 1'b1);
        tick(7);
        s_n[0] = 1'b1; r_n[0] = 1'b1;
        tick(3);
        expect_out("release_to0", 4'b0000, 4'b1111, 4'b0000, 1'b1);

        // Forbidden from stored 1.
        s_n[0] = 1'b0; tick(3); s_n[0] = 1'b1; tick(3);
        s_n[0] = 1'b0; r_n[0] = 1'b0;
        tick(3);
        expect_out("forbid_from1", 4'b0001, 4'b1111, 4'b0001, 1'b1);
        tick(7);
        s_n[0] = 1'b1; r_n[0] = 1'b1;
        tick(3);
        expect_out("release_to1", 4'b0001, 4'b1110, 4'b0000, 1'b1);

        // Normal operation after a forbidden release, then sticky clear.
        r_n[0] = 1'b0; tick(3);
        expect_out("post_forbid_rst", 4'b0000, 4'b1111, 4'b0000, 1'b1);
        r_n[0] = 1'b1; tick(3);
        s_n[0] = 1'b0; tick(3);
        expect_out("post_forbid_set", 4'b0001, 4'b1110, 4'b0000, 1'b1);
        s_n[0] = 1'b1; tick(3);
        clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
        expect_out("sticky_clear", 4'b0001, 4'b1110, 4'b0000, 1'b0);

        // Clear on the same edge that invalid rises: set wins.
        s_n[0] = 1'b0; r_n[0] = 1'b0;
        tick(2);
        clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
        expect_out("set_beats_clear", 4'b0001, 4'b1111, 4'b0001, 1'b1);
        s_n[0] = 1'b1; r_n[0] = 1'b1;
        tick(3);
        clr_sticky = 1'b1; tick(1); clr_sticky = 1'b0;
        expect_out("restore_after_clr", 4'b0001, 4'b1110, 4'b0000, 1'b0);

        // Independent lanes: preload lane1=1, lane0=0.
        s_n = 4'b1101; r_n = 4'b1110; tick(3);
        s_n = '1; r_n = '1; tick(3);
        expect_out("lanes_preload", 4'b0010, 4'b1101, 4'b0000, 1'b0);
        s_n = 4'b1010; r_n = 4'b1001;
        tick(3);
        expect_out("lanes_indep", 4'b0101, 4'b1110, 4'b0100, 1'b1);

        // Asynchronous reset between clock edges.
        #3 rst_n = 1'b0;
        #1 expect_out("async_reset", 4'b0000, 4'b1111, 4'b0000, 1'b0);
        s_n = '1; r_n = '1;
        #3 rst_n = 1'b1;
        tick(5);
        expect_out("after_async_reset", 4'b0000, 4'b1111, 4'b0000, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
